counter_up_mod: RTL
===================

// Module: counter_up_mod
// PURPOSE
//  Up-counting counter with programmable terminal value, synchronous load/clear,
//  wrap or saturate mode, and an optional enable prescaler. It is the
//  incrementing counterpart of the team's down counter and shares its
//  clk/rst_n/en/count interface style. It feeds timers and event-count
//  status registers.
// PARAMETERS
//  WIDTH     4   counter width in bits, >= 2
//  PRESCALE  1   en cycles per increment, >= 1; 1 bypasses the prescaler
// PORTS
//  clk         in   1      clock; all state changes on posedge
//  rst_n       in   1      asynchronous active-low reset
//  en          in   1      count enable, qualified by the prescaler tick
//  clr         in   1      synchronous clear
//  load        in   1      synchronous load of load_val
//  load_val    in   WIDTH  value loaded on load
//  max_val     in   WIDTH  terminal value; the count range is 0..max_val
//  mode_sat    in   1      1 = saturate at max_val; 0 = wrap to 0
//  ovf_clr     in   1      clears ovf
//  count       out  WIDTH  current count, registered
//  tc          out  1      combinational: count >= max_val
//  wrap        out  1      registered 1-cycle pulse on the cycle count shows 0 after a wrap
//  ovf         out  1      sticky overflow flag, registered
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): count=0, wrap=0, ovf=0, prescaler=0.
//    tc then reflects count=0 against max_val. Reset mid-count aborts
//    immediately with no pulse.
//  - Priority per edge: clr > load > increment. No event leaves count unchanged.
//  - clr: count<=0 and prescaler<=0. wrap and ovf are unaffected.
//  - load: count<=min(load_val, max_val) and prescaler<=0.
//  - tick: the prescaler counts 0..PRESCALE-1 only while en=1 and holds while en=0.
//    tick=en && (presc==PRESCALE-1), after which presc returns to 0.
//    With PRESCALE=1, tick=en.
//  - Increment happens on tick with no clr/load, at latency 1 edge:
//      - count < max_val: count+1.
//      - count >= max_val, mode_sat=0: count<=0, then wrap=1 on the next
//        cycle, and ovf<=1.
//      - count >= max_val, mode_sat=1: count holds and ovf<=1. No wrap.
//  - The count >= max_val comparison covers max_val lowered below count at
//    run time. That case is treated as terminal, so there is never a pass
//    through 2^WIDTH.
//  - max_val=0: count stays 0. Each tick is a wrap in wrap mode, or a
//    saturate event in saturate mode.
//  - max_val=2^WIDTH-1: full natural range. The arithmetic never relies on
//    modulo-2^WIDTH overflow; the increment is computed in WIDTH bits and is
//    guarded by the compare.
//  - ovf_clr clears ovf. If ovf_clr coincides with an ovf set event, set wins.
//  - wrap defaults to 0 each cycle and is 1 only for the single cycle after
//    a wrap increment.
//  - mode_sat and max_val are sampled each edge with no shadowing.
//  - The prescaler FSM is modelled as a counter:
//      - states: presc value 0..PRESCALE-1.
//      - transitions: +1 on en; 0 on terminal tick, clr, or load.
// STRUCTURE
//  - Package counter_pkg holds:
//      - typedef enum logic {CNT_WRAP=0, CNT_SAT=1} cnt_mode_e (type of mode_sat)
//      - localparam DEF_WIDTH=4
//  - Sub-module tick_gen (parameter PRESCALE; ports clk, rst_n, en, restart,
//    tick) implements the prescaler. When PRESCALE=1 it is a pass-through,
//    selected by generate.
//  - The top level holds the count register, the compare, and the wrap/ovf flags.
// TESTING
//  Conditions below are WIDTH=4 unless stated otherwise.
//  1. Reset then count: rst_n low 20ns, then en=1, max_val=15, mode_sat=0,
//     PRESCALE=1.
//     -> count steps 0..15 and then 0; wrap is high one cycle at count=0; ovf=1.
//  2. Saturate: max_val=9, mode_sat=1, en=1 for 14 cycles.
//     -> count reaches 9 and holds; tc=1; ovf sets on the first held tick;
//        wrap never asserts.
//  3. Priority: count=5, assert clr, load (load_val=12), and en together.
//     -> count=0.
//     Then load alone with load_val=12, max_val=10.
//     -> count=10 (clamped), tc=1.
//  4. Prescaler: PRESCALE=3, en=1 for 9 cycles.
//     -> count=3.
//     en dropped for 2 cycles mid-period.
//     -> the period stretches by 2 cycles.
//  5. Run-time limit: count=12, max_val changed to 7, wrap mode, one tick.
//     -> count=0, wrap pulse, ovf=1.
//     ovf_clr asserted together with a wrap event.
//     -> ovf stays 1.
//  6. Async reset mid-count: rst_n drops between edges at count=6.
//     -> count=0, wrap=0, ovf=0 immediately (before the next edge).
//     Counting resumes from 0 after release.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and defaults for the up counter and its prescaler.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/tick_gen.sv
// Enable prescaler: one tick every PRESCALE enabled cycles, pass-through when PRESCALE=1.
module tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk, rst_n, restart};
            assign tick = en;
        end else begin : g_presc
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] presc;

            assign tick = en && (presc == LAST);

            // The phase only advances on enabled cycles, so a gap in en stretches the period.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    presc <= '0;
                end else if (restart) begin
                    presc <= '0;
                end else if (en) begin
                    presc <= (presc == LAST) ? '0 : presc + PW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/counter_up_mod.sv
// Up counter with programmable terminal value, load/clear, wrap or saturate mode and prescaled enable.
module counter_up_mod
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  cnt_mode_e        mode_sat,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    logic             tick;
    logic             restart;
    logic [WIDTH-1:0] count_next;
    logic             wrap_next;
    logic             ovf_set;

    assign restart = clr | load;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .restart(restart),
        .tick   (tick)
    );

    // A count above a lowered max_val is terminal too, so the count never runs through 2^WIDTH.
    assign tc = (count >= max_val);

    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        ovf_set    = 1'b0;
        if (clr) begin
            count_next = '0;
        end else if (load) begin
            count_next = (load_val > max_val) ? max_val : load_val;
        end else if (tick) begin
            if (count < max_val) begin
                count_next = count + WIDTH'(1);
            end else if (mode_sat == CNT_WRAP) begin
                count_next = '0;
                wrap_next  = 1'b1;
                ovf_set    = 1'b1;
            end else begin
                ovf_set    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            wrap  <= wrap_next;
            ovf   <= ovf_set | (ovf & ~ovf_clr);
        end
    end

endmodule
